// File: rtl/vedic_32bits_pkg.sv
// Shared widths for the Vedic 32x32 multiplier and its 16x16 building block.
package vedic_32bits_pkg;

    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned HALF_W = 16;

endpackage : vedic_32bits_pkg

// File: rtl/vedic_16bits.sv
// Combinational 16x16 -> 32 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier.
// Built bottom-up: 64 gate-level 2x2 cells, combined into 4x4, 8x8 and finally
// 16x16 products.  Each combine step uses the vertical-and-crosswise identity
// lo*lo + ((hi*lo + lo*hi) << n) + (hi*hi << 2n).
// Ports:
//   a_i      16-bit unsigned multiplicand
//   b_i      16-bit unsigned multiplier
//   prod_c_o 32-bit unsigned product (combinational)
module vedic_16bits
    import vedic_32bits_pkg::*;
(
    input  logic [HALF_W-1:0]   a_i,
    input  logic [HALF_W-1:0]   b_i,
    output logic [2*HALF_W-1:0] prod_c_o
);

    // pp<n>[i][j] = a chunk i (n bits) * b chunk j (n bits)
    logic [3:0]  pp2  [8][8];
    logic [4:0]  mid4 [4][4];
    logic [7:0]  pp4  [4][4];
    logic [8:0]  mid8 [2][2];
    logic [15:0] pp8  [2][2];
    logic [16:0] mid16;

    // 2x2 base cells: one bit of cross-term carry feeds the top pair of bits.
    for (genvar i = 0; i < 8; i++) begin : g_a2
        for (genvar j = 0; j < 8; j++) begin : g_b2
            logic [1:0] x;
            logic [1:0] y;
            logic       hh;
            logic       cross_c;
            assign x       = a_i[2*i +: 2];
            assign y       = b_i[2*j +: 2];
            assign hh      = x[1] & y[1];
            assign cross_c = x[1] & y[0] & x[0] & y[1];
            assign pp2[i][j] = {hh & cross_c,
                                hh ^ cross_c,
                                (x[1] & y[0]) ^ (x[0] & y[1]),
                                x[0] & y[0]};
        end
    end

    // 4x4 from 2x2
    for (genvar i = 0; i < 4; i++) begin : g_a4
        for (genvar j = 0; j < 4; j++) begin : g_b4
            assign mid4[i][j] = {1'b0, pp2[2*i+1][2*j]} + {1'b0, pp2[2*i][2*j+1]};
            assign pp4[i][j]  = {pp2[2*i+1][2*j+1], pp2[2*i][2*j]}
                              + (8'(mid4[i][j]) << 2);
        end
    end

    // 8x8 from 4x4
    for (genvar i = 0; i < 2; i++) begin : g_a8
        for (genvar j = 0; j < 2; j++) begin : g_b8
            assign mid8[i][j] = {1'b0, pp4[2*i+1][2*j]} + {1'b0, pp4[2*i][2*j+1]};
            assign pp8[i][j]  = {pp4[2*i+1][2*j+1], pp4[2*i][2*j]}
                              + (16'(mid8[i][j]) << 4);
        end
    end

    // 16x16 from 8x8
    assign mid16    = {1'b0, pp8[1][0]} + {1'b0, pp8[0][1]};
    assign prod_c_o = {pp8[1][1], pp8[0][0]} + (32'(mid16) << 8);

endmodule : vedic_16bits

// File: rtl/vedic_32bits.sv
// Unsigned 32x32 -> 64 Vedic multiplier with a single registered output stage.
// Four 16x16 partial products are cross-added combinationally; the result is
// captured when in_valid is high, otherwise Q holds its last product.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (clears Q and out_valid)
//   A, B      32-bit unsigned operands
//   in_valid  A/B carry an operation this cycle
//   Q         registered 64-bit product
//   out_valid Q was updated by the previous valid operation
module vedic_32bits
    import vedic_32bits_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    input  logic              in_valid,
    output logic [PROD_W-1:0] Q,
    output logic              out_valid
);

    logic [2*HALF_W-1:0] p0_c;
    logic [2*HALF_W-1:0] p1_c;
    logic [2*HALF_W-1:0] p2_c;
    logic [2*HALF_W-1:0] p3_c;
    logic [2*HALF_W:0]   mid_c;
    logic [PROD_W-1:0]   prod_c;

    logic [PROD_W-1:0]   q_d, q_q;
    logic                valid_d, valid_q;

    // P0 = AL*BL, P1 = AH*BL, P2 = AL*BH, P3 = AH*BH
    vedic_16bits u_p0 (.a_i(A[HALF_W-1:0]),    .b_i(B[HALF_W-1:0]),    .prod_c_o(p0_c));
    vedic_16bits u_p1 (.a_i(A[OP_W-1:HALF_W]), .b_i(B[HALF_W-1:0]),    .prod_c_o(p1_c));
    vedic_16bits u_p2 (.a_i(A[HALF_W-1:0]),    .b_i(B[OP_W-1:HALF_W]), .prod_c_o(p2_c));
    vedic_16bits u_p3 (.a_i(A[OP_W-1:HALF_W]), .b_i(B[OP_W-1:HALF_W]), .prod_c_o(p3_c));

    // Cross terms need 33 bits; P3 and P0 never overlap so they concatenate.
    always_comb begin
        mid_c  = {1'b0, p1_c} + {1'b0, p2_c};
        prod_c = {p3_c, p0_c} + (PROD_W'(mid_c) << HALF_W);
    end

    // Capture only on valid so operand garbage while idle cannot reach Q.
    always_comb begin
        q_d     = q_q;
        valid_d = 1'b0;
        if (in_valid) begin
            q_d     = prod_c;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            valid_q <= valid_d;
        end
    end

    assign Q         = q_q;
    assign out_valid = valid_q;

endmodule : vedic_32bits

// File: tb/tb_vedic_32bits.sv
module tb_vedic_32bits;

    logic        clk;
    logic        rst;
    logic [31:0] A;
    logic [31:0] B;
    logic        in_valid;
    logic [63:0] Q;
    logic        out_valid;

    typedef struct packed {
        logic        v;
        logic [63:0] q;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [63:0] model_q = 64'd0;

    vedic_32bits dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .Q         (Q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue what Q/out_valid must show after
    // the next rising edge, from the plain arithmetic rules.
    task automatic step(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        if (r) begin
            model_q = 64'd0;
            e.v     = 1'b0;
        end else if (v) begin
            model_q = {32'd0, a} * {32'd0, b};
            e.v     = 1'b1;
        end else begin
            e.v     = 1'b0;
        end
        e.q = model_q;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one result per clock, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (out_valid !== e.v) begin
                    errors++;
                    $display("FAIL out_valid got %b want %b at %0t", out_valid, e.v, $time);
                end
                checks++;
                if (Q !== e.q) begin
                    errors++;
                    $display("FAIL Q got %h want %h at %0t", Q, e.q, $time);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        // reset held with a valid op present
        step(1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0);
        step(1'b1, 1'b1, 32'h12345678, 32'h9ABCDEF0);
        // basic product, then hold while idle with garbage operands
        step(1'b0, 1'b1, 32'd3, 32'd5);
        step(1'b0, 1'b0, $urandom, $urandom);
        step(1'b0, 1'b0, $urandom, $urandom);
        // boundaries
        step(1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step(1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000001);
        step(1'b0, 1'b1, 32'h0000FFFF, 32'hFFFF0000);
        step(1'b0, 1'b1, 32'h80000000, 32'h00000002);
        step(1'b0, 1'b1, 32'h00000000, $urandom);
        step(1'b0, 1'b1, $urandom, 32'h00000000);
        step(1'b0, 1'b1, 32'hFFFF0000, 32'h0000FFFF);
        // back-to-back random
        for (int i = 0; i < 50; i++) begin
            step(1'b0, 1'b1, $urandom, $urandom);
        end
        // random mix of idle and valid cycles
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
        // reset mid-stream, then resume
        step(1'b0, 1'b1, $urandom, $urandom);
        step(1'b1, 1'b1, 32'd7, 32'd9);
        step(1'b0, 1'b0, $urandom, $urandom);
        step(1'b0, 1'b1, 32'd7, 32'd9);
        step(1'b0, 1'b0, $urandom, $urandom);
        step(1'b0, 1'b1, $urandom, $urandom);
        in_valid = 1'b0;
        rst      = 1'b0;
        // drain with a bounded wait
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vedic_32bits
